oc_test_seq_ctrl: RTL and testbench
===================================

# oc_test_seq_ctrl

Sequencer for the overclocking test platform. It generates pseudo-random operand vectors for the overclocked DUT and compares the DUT result against a golden result from a safe-clocked copy. It counts mismatches and drives the ILA capture bus and trigger byte. The VIO start/clear bits control runs from the host.

## Interface
Parameters:
- DATA_W, 16: operand/result width; ila_data width is 2*DATA_W+13.
- RUN_LEN, 1024: vectors per run; must be ≥1, ≤65536.
- SETTLE, 2: wait cycles between issue and compare; must be ≥1, ≤15.
- ERR_W, 16: width of the error counter.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- vio_start, in, 1: VIO async level; a rising edge starts a run.
- vio_clear, in, 1: VIO async level; high aborts and clears.
- dut_a, out, DATA_W: operand A to the DUT.
- dut_b, out, DATA_W: operand B to the DUT.
- dut_valid, out, 1: operands issued this cycle.
- dut_result, in, DATA_W: DUT output.
- golden_result, in, DATA_W: safe-clock reference output.
- ila_data, out, 2*DATA_W+13: {state[2:0], vec_cnt[9:0], golden_result, dut_result}, registered.
- trig0, out, 8: trigger byte to ILA.
- busy, out, 1: run in progress.
- done, out, 1: run finished; held until next start or clear.
- err_count, out, ERR_W: saturating mismatch count.

## Operation
- vio_start and vio_clear each pass through a 2-flop synchronizer. start_pulse is the rising edge of the synchronized vio_start.
- FSM states and codes: IDLE=0, LOAD=1, ISSUE=2, WAIT=3, CHECK=4, DONE=5.
- IDLE/DONE → LOAD on start_pulse.
- LOAD: seed LFSR to 32'hACE1_1234, clear vec_cnt and err_count, clear done, set busy. Next state is ISSUE.
- ISSUE: drive dut_a=lfsr[31:16] and dut_b=lfsr[15:0] (low DATA_W bits of each half). Assert dut_valid for exactly this cycle and load wait_cnt=SETTLE. Next state is WAIT.
- WAIT: decrement wait_cnt; go to CHECK when it reaches 1. Operands are held stable throughout WAIT.
- CHECK: mismatch = (dut_result != golden_result). On mismatch, err_count increments, saturating at all-ones. Advance the LFSR one step (Galois, taps x^32+x^22+x^2+x+1).
  - If vec_cnt==RUN_LEN-1, go to DONE, set done, clear busy.
  - Otherwise increment vec_cnt and go to ISSUE.
- A start_pulse while busy is ignored.
- Synchronized vio_clear high in any state forces IDLE and clears busy, done, err_count and vec_cnt. Clear takes priority over start in the same cycle.
- trig0 bits:
  - [0] mismatch pulse, CHECK only.
  - [1] LOAD pulse.
  - [2] one-cycle pulse on entering DONE.
  - [3] err_count saturated, level.
  - [6:4] state code.
  - [7] 0.

## Timing
- Reset value of every output is 0; the state is IDLE.
- From the vio_start rise to LOAD: 2 sync cycles plus 1 edge cycle; LOAD is registered in the 3rd–4th clk.
- Per vector: SETTLE+2 cycles (ISSUE, SETTLE×WAIT, CHECK).
- Run length from LOAD to DONE entry: 1 + RUN_LEN*(SETTLE+2) cycles.
- Comparison samples dut_result/golden_result in the CHECK cycle, SETTLE+1 cycles after dut_valid.
- ila_data and trig0 are registered and lag the FSM by one cycle; they stay mutually aligned.
- err_count updates the cycle after CHECK.
- dut_a and dut_b hold their value outside ISSUE/WAIT; dut_valid is 0 outside ISSUE.
- Reset mid-run returns the block to IDLE immediately (async). There is no partial-state recovery.

## Configuration
- OC_TSC_STOP_ON_ERR_EN defined: the first mismatch in CHECK goes straight to DONE, with vec_cnt frozen at the failing index. err_count is then 1, and ila_data holds the failing vector.
- Not defined: the run always completes all RUN_LEN vectors.

## Structure
- Package oc_tsc_pkg holds:
  - state enum and codes;
  - trig0 bit index constants;
  - LFSR seed and tap mask;
  - ila_data field offsets.
- Sub-module oc_tsc_lfsr is a 32-bit Galois LFSR with inputs load and step and a 32-bit output. The FSM, synchronizers, counters and output registers stay in the top.

## Test plan
- RUN_LEN=8, SETTLE=2, golden tied to dut_result, pulse start: done rises 33 cycles after LOAD, err_count=0, 8 dut_valid pulses, trig0[2] pulses once.
- Same config, mismatch forced on vector 3 only: err_count=1, trig0[0] pulses once while ila_data vec_cnt field=3.
- ERR_W=4, RUN_LEN=20, all vectors mismatch: err_count saturates at 15, trig0[3]=1 from the 15th mismatch onward.
- vio_clear high during WAIT of vector 5: within 3 cycles state=IDLE, busy=0, err_count=0; a later start runs a full clean run.
- Second start pulse during busy is ignored (vector count stays 8). rst_n low mid-run returns all outputs to 0 asynchronously.
- OC_TSC_STOP_ON_ERR_EN, mismatch at vector 2: DONE entered right after that CHECK, vec_cnt=2, err_count=1, only 3 dut_valid pulses.

Source files
------------

// File: rtl/oc_tsc_pkg.sv
// oc_tsc_pkg: shared types and constants for the overclock test sequencer.
// State codes, trigger bit positions, LFSR seed/taps and ILA field layout.
package oc_tsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int TRIG_MISMATCH = 0;
  localparam int TRIG_LOAD     = 1;
  localparam int TRIG_DONE     = 2;
  localparam int TRIG_SAT      = 3;
  localparam int TRIG_STATE_LO = 4;

  localparam logic [31:0] LFSR_SEED = 32'hACE1_1234;
  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int ILA_VEC_W   = 10;
  localparam int ILA_STATE_W = 3;

  function automatic int ila_golden_lo(input int data_w);
    return data_w;
  endfunction

  function automatic int ila_vec_lo(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int ila_state_lo(input int data_w);
    return 2 * data_w + ILA_VEC_W;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/oc_tsc_lfsr.sv
// oc_tsc_lfsr: 32-bit Galois LFSR; load reseeds, step advances one position.
module oc_tsc_lfsr
  import oc_tsc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/oc_test_seq_ctrl.sv
// oc_test_seq_ctrl: issues LFSR operands to an overclocked DUT, compares against a golden copy,
// counts mismatches and feeds the ILA. Define OC_TSC_STOP_ON_ERR_EN to end a run at the first mismatch.
module oc_test_seq_ctrl
  import oc_tsc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RUN_LEN = 1024,
  parameter int SETTLE  = 2,
  parameter int ERR_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vio_start,
  input  logic                  vio_clear,
  output logic [DATA_W-1:0]     dut_a,
  output logic [DATA_W-1:0]     dut_b,
  output logic                  dut_valid,
  input  logic [DATA_W-1:0]     dut_result,
  input  logic [DATA_W-1:0]     golden_result,
  output logic [2*DATA_W+12:0]  ila_data,
  output logic [7:0]            trig0,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_W-1:0]      err_count
);

  localparam int VEC_W     = 16;
  localparam int ILA_W     = 2*DATA_W + 13;
  localparam int GOLDEN_LO = ila_golden_lo(DATA_W);
  localparam int VEC_LO    = ila_vec_lo(DATA_W);
  localparam int STATE_LO  = ila_state_lo(DATA_W);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(RUN_LEN - 1);

  state_t             state, state_next;
  logic [1:0]         start_sync, clear_sync;
  logic               start_prev, start_pulse, clear_s;
  logic [VEC_W-1:0]   vec_cnt;
  logic [3:0]         wait_cnt;
  logic [DATA_W-1:0]  a_hold, b_hold, op_a, op_b;
  logic [31:0]        lfsr_value;
  logic               lfsr_load, lfsr_step, mismatch;
  logic [7:0]         trig_next;
  logic [ILA_W-1:0]   ila_next;

  // VIO levels are asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      clear_sync <= '0;
      start_prev <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], vio_start};
      clear_sync <= {clear_sync[0], vio_clear};
      start_prev <= start_sync[1];
    end
  end

  assign start_pulse = start_sync[1] & ~start_prev;
  assign clear_s     = clear_sync[1];

  oc_tsc_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  assign lfsr_load = (state == ST_LOAD);
  assign lfsr_step = (state == ST_CHECK);
  assign mismatch  = (state == ST_CHECK) && (dut_result != golden_result);
  assign op_a      = lfsr_value[16 +: DATA_W];
  assign op_b      = lfsr_value[0 +: DATA_W];

  always_comb begin
    state_next = state;
    if (clear_s) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start_pulse) state_next = ST_LOAD;
        ST_LOAD:  state_next = ST_ISSUE;
        ST_ISSUE: state_next = ST_WAIT;
        ST_WAIT:  if (wait_cnt == 4'd1) state_next = ST_CHECK;
        ST_CHECK: begin
`ifdef OC_TSC_STOP_ON_ERR_EN
          if (vec_cnt == LAST_VEC || mismatch) state_next = ST_DONE;
`else
          if (vec_cnt == LAST_VEC) state_next = ST_DONE;
`endif
          else state_next = ST_ISSUE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec_cnt   <= '0;
      wait_cnt  <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_hold    <= '0;
      b_hold    <= '0;
    end else begin
      state <= state_next;
      if (clear_s) begin
        vec_cnt   <= '0;
        err_count <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            vec_cnt   <= '0;
            err_count <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
          ST_ISSUE: begin
            wait_cnt <= 4'(SETTLE);
            a_hold   <= op_a;
            b_hold   <= op_b;
          end
          ST_WAIT: wait_cnt <= wait_cnt - 4'd1;
          ST_CHECK: begin
            if (mismatch && !(&err_count)) err_count <= err_count + ERR_W'(1);
            if (state_next == ST_DONE) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              vec_cnt <= vec_cnt + VEC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Operands come straight from the LFSR during ISSUE, then hold until the next ISSUE
  assign dut_valid = (state == ST_ISSUE);
  assign dut_a     = (state == ST_ISSUE) ? op_a : a_hold;
  assign dut_b     = (state == ST_ISSUE) ? op_b : b_hold;

  always_comb begin
    trig_next                              = '0;
    trig_next[TRIG_MISMATCH]               = mismatch;
    trig_next[TRIG_LOAD]                   = (state == ST_LOAD);
    trig_next[TRIG_DONE]                   = (state != ST_DONE) && (state_next == ST_DONE);
    trig_next[TRIG_SAT]                    = &err_count;
    trig_next[TRIG_STATE_LO +: ILA_STATE_W] = state;
  end

  always_comb begin
    ila_next                           = '0;
    ila_next[0 +: DATA_W]              = dut_result;
    ila_next[GOLDEN_LO +: DATA_W]      = golden_result;
    ila_next[VEC_LO +: ILA_VEC_W]      = vec_cnt[ILA_VEC_W-1:0];
    ila_next[STATE_LO +: ILA_STATE_W]  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ila_data <= '0;
      trig0    <= '0;
    end else begin
      ila_data <= ila_next;
      trig0    <= trig_next;
    end
  end

endmodule

// File: tb/tb_oc_test_seq_ctrl.sv
// tb_oc_test_seq_ctrl: randomized self-checking bench for oc_test_seq_ctrl against a run-level model.
// Expectations follow OC_TSC_STOP_ON_ERR_EN when it is defined.
module tb_oc_test_seq_ctrl;
  localparam int DATA_W  = 16;
  localparam int RUN_LEN = 20;
  localparam int SETTLE  = 2;
  localparam int ERR_W   = 4;
  localparam int ILA_W   = 2*DATA_W + 13;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int RUN_CYC = 1 + RUN_LEN*(SETTLE+2);

  logic clk = 1'b0, rst_n = 1'b0, vio_start = 1'b0, vio_clear = 1'b0;
  logic [DATA_W-1:0] dut_a, dut_b, dut_result, golden_result;
  logic dut_valid, busy, done;
  logic [ILA_W-1:0] ila_data;
  logic [7:0] trig0;
  logic [ERR_W-1:0] err_count;

  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  oc_test_seq_ctrl #(.DATA_W(DATA_W), .RUN_LEN(RUN_LEN), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .vio_start(vio_start), .vio_clear(vio_clear),
    .dut_a(dut_a), .dut_b(dut_b), .dut_valid(dut_valid),
    .dut_result(dut_result), .golden_result(golden_result),
    .ila_data(ila_data), .trig0(trig0), .busy(busy), .done(done), .err_count(err_count)
  );

  // The "overclocked DUT" is an adder; golden is corrupted on vectors selected by mask
  logic [DATA_W-1:0] flip_val = '0;
  logic [DATA_W-1:0] flip_pat = 16'h0001;
  bit mask [RUN_LEN];
  assign dut_result    = dut_a + dut_b;
  assign golden_result = dut_result ^ flip_val;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] obs_ops [$];
  int mism_vecs [$];
  int valid_total = 0, mism_total = 0, done_pulse_total = 0, load_total = 0;
  int load_cyc = -1, done_cyc = -1, sat_rise_mism = -1, run_base = 0;
  logic done_prev = 1'b0, t3_prev = 1'b0;
  int mon_v;

  always @(negedge clk) begin
    if (trig0[3] && !t3_prev) sat_rise_mism = mism_total;
    if (dut_valid) begin
      mon_v = valid_total - run_base;
      obs_ops.push_back({dut_a, dut_b});
      flip_val = (mon_v >= 0 && mon_v < RUN_LEN && mask[mon_v]) ? flip_pat : '0;
      valid_total++;
    end
    if (trig0[0]) begin
      mism_total++;
      mism_vecs.push_back(int'(ila_data[2*DATA_W +: 10]));
    end
    if (trig0[1]) begin
      load_cyc = cyc - 1;
      load_total++;
    end
    if (trig0[2]) done_pulse_total++;
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
    t3_prev   = trig0[3];
  end

  // Polynomial x^32+x^22+x^2+x+1, shifting toward bit 0; the bit leaving feeds the tap positions
  function automatic logic [31:0] model_lfsr(input logic [31:0] x);
    logic [31:0] y;
    y = {1'b0, x[31:1]};
    if (x[0]) begin
      y[31] = ~y[31];
      y[21] = ~y[21];
      y[1]  = ~y[1];
      y[0]  = ~y[0];
    end
    return y;
  endfunction

  function automatic void model_run(output int n_vec, output int n_err, output int n_mis);
    n_vec = RUN_LEN;
    n_mis = 0;
    for (int v = 0; v < RUN_LEN; v++) begin
      if (mask[v]) begin
        n_mis++;
`ifdef OC_TSC_STOP_ON_ERR_EN
        n_vec = v + 1;
        break;
`endif
      end
    end
    n_err = (n_mis > ERR_MAX) ? ERR_MAX : n_mis;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    vio_start = 1'b1;
    repeat (5) @(negedge clk);
    vio_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (dut_a !== '0 || dut_b !== '0) $display("FAIL reset_operands: got a=%h b=%h want 0", dut_a, dut_b); else pass_cnt++;
    total_cnt++; if (dut_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dut_valid); else pass_cnt++;
    total_cnt++; if (ila_data !== '0) $display("FAIL reset_ila: got %h want 0", ila_data); else pass_cnt++;
    total_cnt++; if (trig0 !== 8'h00) $display("FAIL reset_trig0: got %h want 00", trig0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
    total_cnt++; if (err_count !== '0) $display("FAIL reset_err: got %0d want 0", err_count); else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || dut_valid !== 1'b0 || trig0 !== 8'h00)
      $display("FAIL idle_after_reset: got busy=%b done=%b valid=%b trig0=%h want 0 0 0 00", busy, done, dut_valid, trig0); else pass_cnt++;
  endtask

  task automatic test_clean_run();
    int n_vec, n_err, n_mis, vb, db;
    bit ok;
    logic [31:0] lf;
    for (int v = 0; v < RUN_LEN; v++) mask[v] = 1'b0;
    model_run(n_vec, n_err, n_mis);
    vb = valid_total; db = done_pulse_total; run_base = valid_total;
    pulse_start();
    wait_done(400, ok);
    total_cnt++; if (!ok) $display("FAIL clean_timeout: got done=%b busy=%b want done=1 busy=0", done, busy); else pass_cnt++;
    total_cnt++; if (done_cyc - load_cyc !== 1 + n_vec*(SETTLE+2))
      $display("FAIL clean_latency: got %0d cycles want %0d", done_cyc - load_cyc, 1 + n_vec*(SETTLE+2)); else pass_cnt++;
    total_cnt++; if (valid_total - vb !== n_vec) $display("FAIL clean_valid_count: got %0d want %0d", valid_total - vb, n_vec); else pass_cnt++;
    total_cnt++; if (err_count !== ERR_W'(n_err)) $display("FAIL clean_err: got %0d want %0d", err_count, n_err); else pass_cnt++;
    total_cnt++; if (done_pulse_total - db !== 1) $display("FAIL clean_done_pulse: got %0d want 1", done_pulse_total - db); else pass_cnt++;
    total_cnt++; if (int'(ila_data[2*DATA_W +: 10]) !== RUN_LEN - 1)
      $display("FAIL clean_ila_vec: got %0d want %0d", ila_data[2*DATA_W +: 10], RUN_LEN - 1); else pass_cnt++;
    total_cnt++; if (trig0[6:4] !== 3'd5) $display("FAIL clean_trig_state: got %0d want 5", trig0[6:4]); else pass_cnt++;
    lf = 32'hACE1_1234;
    for (int v = 0; v < n_vec; v++) begin
      total_cnt++;
      if (vb + v >= obs_ops.size()) $display("FAIL clean_operands[%0d]: got none want %h", v, lf);
      else if (obs_ops[vb + v] !== lf) $display("FAIL clean_operands[%0d]: got %h want %h", v, obs_ops[vb + v], lf);
      else pass_cnt++;
      lf = model_lfsr(lf);
    end
  endtask

  task automatic test_single_mismatch();
    int n_vec, n_err, n_mis, vb, mb;
    bit ok;
    for (int v = 0; v < RUN_LEN; v++) mask[v] = (v == 3);
    flip_pat = DATA_W'($urandom_range(1, 16'hFFFF));
    model_run(n_vec, n_err, n_mis);
    vb = valid_total; mb = mism_total; run_base = valid_total;
    pulse_start();
    wait_done(400, ok);
    total_cnt++; if (!ok) $display("FAIL single_timeout: got done=%b want 1", done); else pass_cnt++;
    total_cnt++; if (err_count !== ERR_W'(n_err)) $display("FAIL single_err: got %0d want %0d", err_count, n_err); else pass_cnt++;
    total_cnt++; if (mism_total - mb !== 1) $display("FAIL single_trig_pulses: got %0d want 1", mism_total - mb); else pass_cnt++;
    total_cnt++; if (mism_vecs.size() == 0 || mism_vecs[$] !== 3)
      $display("FAIL single_ila_vec: got %0d want 3", (mism_vecs.size() == 0) ? -1 : mism_vecs[$]); else pass_cnt++;
    total_cnt++; if (valid_total - vb !== n_vec) $display("FAIL single_valid_count: got %0d want %0d", valid_total - vb, n_vec); else pass_cnt++;
    total_cnt++; if (int'(ila_data[2*DATA_W +: 10]) !== n_vec - 1)
      $display("FAIL single_final_vec: got %0d want %0d", ila_data[2*DATA_W +: 10], n_vec - 1); else pass_cnt++;
  endtask

  task automatic test_random_mismatch();
    int n_vec, n_err, n_mis, vb, mb;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < RUN_LEN; v++) mask[v] = ($urandom_range(0, 3) == 0);
      flip_pat = DATA_W'($urandom_range(1, 16'hFFFF));
      model_run(n_vec, n_err, n_mis);
      vb = valid_total; mb = mism_total; run_base = valid_total;
      pulse_start();
      wait_done(400, ok);
      total_cnt++; if (!ok || err_count !== ERR_W'(n_err))
        $display("FAIL random_err[%0d]: got %0d (done=%b) want %0d", r, err_count, done, n_err); else pass_cnt++;
      total_cnt++; if (valid_total - vb !== n_vec || mism_total - mb !== n_mis)
        $display("FAIL random_counts[%0d]: got vec=%0d mis=%0d want vec=%0d mis=%0d", r, valid_total - vb, mism_total - mb, n_vec, n_mis); else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int n_vec, n_err, n_mis, mb;
    bit ok;
    for (int v = 0; v < RUN_LEN; v++) mask[v] = 1'b1;
    flip_pat = DATA_W'($urandom_range(1, 16'hFFFF));
    model_run(n_vec, n_err, n_mis);
    mb = mism_total; run_base = valid_total;
    pulse_start();
    wait_done(400, ok);
    total_cnt++; if (!ok || err_count !== ERR_W'(n_err))
      $display("FAIL sat_err: got %0d (done=%b) want %0d", err_count, done, n_err); else pass_cnt++;
`ifndef OC_TSC_STOP_ON_ERR_EN
    total_cnt++; if (trig0[3] !== 1'b1) $display("FAIL sat_trig_level: got %b want 1", trig0[3]); else pass_cnt++;
    total_cnt++; if (sat_rise_mism - mb !== ERR_MAX)
      $display("FAIL sat_trig_onset: got rise after %0d mismatches want %0d", sat_rise_mism - mb, ERR_MAX); else pass_cnt++;
`endif
  endtask

  task automatic test_start_while_busy();
    int vb, db, lb;
    bit ok;
    for (int v = 0; v < RUN_LEN; v++) mask[v] = 1'b0;
    vb = valid_total; db = done_pulse_total; lb = load_total; run_base = valid_total;
    pulse_start();
    repeat (20) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL busy_midrun: got %b want 1", busy); else pass_cnt++;
    pulse_start();
    wait_done(400, ok);
    total_cnt++; if (!ok || valid_total - vb !== RUN_LEN)
      $display("FAIL restart_ignored: got %0d vectors (done=%b) want %0d", valid_total - vb, done, RUN_LEN); else pass_cnt++;
    total_cnt++; if (load_total - lb !== 1 || done_pulse_total - db !== 1)
      $display("FAIL restart_pulses: got load=%0d done=%0d want 1 1", load_total - lb, done_pulse_total - db); else pass_cnt++;
  endtask

  task automatic test_clear();
    int seen, vb, want_err;
    bit ok;
    for (int v = 0; v < RUN_LEN; v++) mask[v] = 1'b0;
`ifndef OC_TSC_STOP_ON_ERR_EN
    for (int v = 0; v < 5; v++) mask[v] = 1'b1;
`endif
    want_err = 0;
    for (int v = 0; v < 5; v++) if (mask[v]) want_err++;
    run_base = valid_total;
    pulse_start();
    seen = 1;
    for (int i = 0; i < 200 && seen < 6; i++) begin
      @(negedge clk);
      if (dut_valid) seen++;
    end
    total_cnt++; if (seen !== 6 || err_count !== ERR_W'(want_err))
      $display("FAIL clear_precondition: got issued=%0d err=%0d want 6 %0d", seen, err_count, want_err); else pass_cnt++;
    @(posedge clk); #1;
    vio_clear = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || err_count !== '0 || dut_valid !== 1'b0)
      $display("FAIL clear_effect: got busy=%b done=%b err=%0d valid=%b want 0 0 0 0", busy, done, err_count, dut_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (trig0[6:4] !== 3'd0) $display("FAIL clear_state: got %0d want 0", trig0[6:4]); else pass_cnt++;
    vio_clear = 1'b0;
    repeat (4) @(negedge clk);
    for (int v = 0; v < RUN_LEN; v++) mask[v] = 1'b0;
    vb = valid_total; run_base = valid_total;
    pulse_start();
    wait_done(400, ok);
    total_cnt++; if (!ok || valid_total - vb !== RUN_LEN || err_count !== '0)
      $display("FAIL clear_rerun: got vec=%0d err=%0d done=%b want %0d 0 1", valid_total - vb, err_count, done, RUN_LEN); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int v = 0; v < RUN_LEN; v++) mask[v] = (v == 0);
    run_base = valid_total;
    pulse_start();
    repeat (10) @(negedge clk);
    total_cnt++; if (busy !== 1'b1 || err_count !== ERR_W'(1))
      $display("FAIL arst_precondition: got busy=%b err=%0d want 1 1", busy, err_count); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || err_count !== '0 || dut_valid !== 1'b0)
      $display("FAIL arst_status: got busy=%b done=%b err=%0d valid=%b want 0 0 0 0", busy, done, err_count, dut_valid); else pass_cnt++;
    total_cnt++; if (dut_a !== '0 || dut_b !== '0 || ila_data !== '0 || trig0 !== 8'h00)
      $display("FAIL arst_data: got a=%h b=%h ila=%h trig0=%h want 0", dut_a, dut_b, ila_data, trig0); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int v = 0; v < RUN_LEN; v++) mask[v] = 1'b0;
    test_reset();
    test_clean_run();
    test_single_mismatch();
    test_random_mismatch();
    test_saturation();
    test_start_while_busy();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
